// File: rtl/mole_game_engine.sv
// Whack-a-mole game engine: fetches position patterns, shows one mole at a time,
// resolves each mole as hit/miss from a key strobe or a tick-based timeout.
module mole_game_engine #(
    parameter int N_SLOTS  = 8,
    parameter int POS_W    = 4,
    parameter int TICK_DIV = 3,
    parameter int TIMEOUT  = 4,
    parameter int ROUNDS   = 30
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       start,
    input  logic                       speedup,
    input  logic [N_SLOTS*POS_W-1:0]   pat_data,
    input  logic                       pat_valid,
    output logic                       pat_ready,
    output logic                       pat_req,
    input  logic [POS_W-1:0]           key_code,
    input  logic                       key_valid,
    output logic [POS_W-1:0]           mole_pos,
    output logic                       mole_on,
    output logic                       hit,
    output logic                       miss,
    output logic [7:0]                 score,
    output logic [7:0]                 round_cnt,
    output logic                       game_over
);

    localparam int IDX_W = $clog2(N_SLOTS);
    localparam int PRE_W = $clog2(TICK_DIV);
    localparam logic [IDX_W-1:0] LAST_SLOT   = IDX_W'(N_SLOTS - 1);
    localparam logic [PRE_W-1:0] PRE_LAST    = PRE_W'(TICK_DIV - 1);
    localparam logic [7:0]       WINDOW_INIT = 8'(TIMEOUT);
    localparam logic [8:0]       ROUNDS_9    = 9'(ROUNDS);

    typedef enum logic [1:0] {IDLE, WAIT_PAT, SHOW, DONE} state_t;

    state_t                     state, state_next;
    logic                       start_game;
    logic [N_SLOTS*POS_W-1:0]   pattern;
    logic [POS_W-1:0]           slots [N_SLOTS];
    logic [IDX_W-1:0]           slot_idx;
    logic [PRE_W-1:0]           presc;
    logic [7:0]                 tick_cnt;
    logic [7:0]                 window;
    logic                       speed_mode;
    logic [POS_W-1:0]           cur_pos;
    logic                       tick, timeout, resolve, key_hit, last_round, last_slot;

    for (genvar k = 0; k < N_SLOTS; k++) begin : g_slots
        assign slots[k] = pattern[k*POS_W +: POS_W];
    end

    assign cur_pos   = slots[slot_idx];
    assign mole_on   = (state == SHOW);
    assign mole_pos  = mole_on ? cur_pos : '0;
    // Pattern handshake: a transfer happens on a clock edge where pat_valid and
    // pat_ready are both high; pat_ready is high exactly while waiting for a pattern.
    assign pat_ready = (state == WAIT_PAT);
    assign game_over = (state == DONE);

    assign tick       = (state == SHOW) && (presc == PRE_LAST);
    assign timeout    = tick && (tick_cnt == window - 8'd1);
    assign resolve    = (state == SHOW) && (key_valid || timeout);
    assign key_hit    = key_valid && (key_code == cur_pos);
    assign last_round = ({1'b0, round_cnt} + 9'd1) == ROUNDS_9;
    assign last_slot  = (slot_idx == LAST_SLOT);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= state_next;
    end

    always_comb begin
        state_next = state;
        start_game = 1'b0;
        case (state)
            IDLE, DONE: begin
                if (start) begin
                    state_next = WAIT_PAT;
                    start_game = 1'b1;
                end
            end
            WAIT_PAT: if (pat_valid) state_next = SHOW;
            SHOW: begin
                if (resolve) begin
                    if (last_round)     state_next = DONE;
                    else if (last_slot) state_next = WAIT_PAT;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pattern    <= '0;
            slot_idx   <= '0;
            presc      <= '0;
            tick_cnt   <= '0;
            window     <= WINDOW_INIT;
            speed_mode <= 1'b0;
            score      <= '0;
            round_cnt  <= '0;
            hit        <= 1'b0;
            miss       <= 1'b0;
            pat_req    <= 1'b0;
        end else begin
            hit     <= 1'b0;
            miss    <= 1'b0;
            pat_req <= 1'b0;
            if (start_game) begin
                score      <= '0;
                round_cnt  <= '0;
                slot_idx   <= '0;
                window     <= WINDOW_INIT;
                speed_mode <= speedup;
                pat_req    <= 1'b1;
            end
            if (state == WAIT_PAT && pat_valid) begin
                pattern  <= pat_data;
                slot_idx <= '0;
                presc    <= '0;
                tick_cnt <= '0;
            end
            if (state == SHOW) begin
                if (resolve) begin
                    // A key strobe takes precedence over a coincident timeout.
                    hit       <= key_hit;
                    miss      <= ~key_hit;
                    if (key_hit && score != 8'hFF) score <= score + 8'd1;
                    round_cnt <= round_cnt + 8'd1;
                    presc     <= '0;
                    tick_cnt  <= '0;
                    if (!last_round) begin
                        if (last_slot) begin
                            pat_req <= 1'b1;
                            if (speed_mode && window > 8'd1) window <= window - 8'd1;
                        end else begin
                            slot_idx <= slot_idx + 1'b1;
                        end
                    end
                end else if (tick) begin
                    presc    <= '0;
                    tick_cnt <= tick_cnt + 8'd1;
                end else begin
                    presc <= presc + 1'b1;
                end
            end
        end
    end

endmodule
